// File: rtl/crypto.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : crypto                                                      |
// | Description : 4-bit positional XOR nibble cipher with one registered      |
// |               output stage; the same operation encrypts and decrypts.     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module crypto (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic key3,
  input  logic key2,
  input  logic key1,
  input  logic key0,
  output logic y3,
  output logic y2,
  output logic y1,
  output logic y0
);

  logic [3:0] w_cipher;
  logic [3:0] r_y;

  assign w_cipher = {a, b, c, d} ^ {key3, key2, key1, key0};

  // The four output flops are the only state; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= 4'b0000;
    end else begin
      r_y <= w_cipher;
    end
  end

  assign {y3, y2, y1, y0} = r_y;

endmodule
`default_nettype wire

// File: tb/tb_crypto.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_crypto                                                   |
// | Description : Self-checking scoreboard bench for the crypto nibble cipher.|
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_crypto;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic key3, key2, key1, key0;
  logic y3, y2, y1, y0;
  logic [3:0] w_y;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  crypto u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .key3 (key3),
    .key2 (key2),
    .key1 (key1),
    .key0 (key0),
    .y3   (y3),
    .y2   (y2),
    .y1   (y1),
    .y0   (y0)
  );

  assign w_y = {y3, y2, y1, y0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one data/key pair and record the cipher the bench expects for it.
  task automatic drive(input logic [3:0] dt, input logic [3:0] k);
    {a, b, c, d}             = dt;
    {key3, key2, key1, key0} = k;
    exp_q.push_back(dt ^ k);
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=%b expected=<queue empty>", tag, w_y);
    end else begin
      e = exp_q.pop_front();
      check(tag, w_y, e);
    end
  endtask

  // Drive at the falling edge, compare just after the next rising edge.
  task automatic step(input logic [3:0] dt, input logic [3:0] k, input string tag);
    @(negedge clk);
    drive(dt, k);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    logic [7:0] iv;
    logic [3:0] ct;
    checks   = 0;
    failures = 0;

    // Reset held low while the clock runs
    rst_n = 1'b0;
    {a, b, c, d}             = 4'b1010;
    {key3, key2, key1, key0} = 4'b0101;
    #1;
    check("reset_t0", w_y, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("reset_hold", w_y, 4'b0000);
    end

    // First edge after release takes data^key
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1010, 4'b0101);
    @(posedge clk);
    #1;
    pop_check("reset_release");

    // Asynchronous assertion between edges while y=1111
    step(4'b0000, 4'b1111, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", w_y, 4'b0000);
    @(negedge clk);
    check("async_reset_hold", w_y, 4'b0000);
    rst_n = 1'b1;

    // Exhaustive sweep {a,b,c,d,key3..key0} = i
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      step(iv[7:4], iv[3:0], "sweep");
      case (iv)
        8'h00: check("spot_00", w_y, 4'b0000);
        8'hFF: check("spot_FF", w_y, 4'b0000);
        8'hA5: check("spot_A5", w_y, 4'b1111);
        8'h3C: check("spot_3C", w_y, 4'b1111);
        8'h90: check("spot_90", w_y, 4'b1001);
        default: ;
      endcase
    end

    // Latency: input change just after an edge is not seen until the next edge
    step(4'b0001, 4'b0000, "lat_first");
    drive(4'b1110, 4'b0000);
    #3;
    check("lat_hold", w_y, 4'b0001);
    @(negedge clk);
    check("lat_hold_neg", w_y, 4'b0001);
    @(posedge clk);
    #1;
    pop_check("lat_update");

    // Round trip with the same key
    ct = 4'b1011 ^ 4'b0110;
    step(4'b1011, 4'b0110, "enc");
    check("enc_const", w_y, 4'b1101);
    step(ct, 4'b0110, "dec");
    check("dec_const", w_y, 4'b1011);

    // Mid-stream reset pulse discards the in-flight result
    step(4'b1111, 4'b0000, "stream0");
    step(4'b0000, 4'b0000, "stream1");
    step(4'b1111, 4'b0000, "stream2");
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_reset_pulse", w_y, 4'b0000);
    @(negedge clk);
    check("mid_reset_low", w_y, 4'b0000);
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000);
    @(posedge clk);
    #1;
    pop_check("mid_reset_release");
    step(4'b0000, 4'b0000, "stream3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crypto.md
Name: crypto

Overview:
- 4-bit symmetric XOR cipher. It combines a 4-bit data nibble {a,b,c,d} with a 4-bit key {key3..key0} and presents the 4-bit result on y3..y0.
- The output is registered: one clock of latency, cleared by reset.
- Sits as a leaf datapath block for nibble-wide encrypt/decrypt. Encryption and decryption are the same operation with the same key.

Parameters:
- none (all widths fixed at 1-bit scalar ports, 4-bit logical nibbles)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  1  data bit 3 (MSB of data nibble)
- b  input  1  data bit 2
- c  input  1  data bit 1
- d  input  1  data bit 0 (LSB)
- key3  input  1  key bit 3 (MSB)
- key2  input  1  key bit 2
- key1  input  1  key bit 1
- key0  input  1  key bit 0 (LSB)
- y3  output  1  cipher bit 3 (MSB)
- y2  output  1  cipher bit 2
- y1  output  1  cipher bit 1
- y0  output  1  cipher bit 0 (LSB)

Behaviour:
- Bit mapping, strictly positional:
  - y3 = a ^ key3
  - y2 = b ^ key2
  - y1 = c ^ key1
  - y0 = d ^ key0
- Equivalently, {y3,y2,y1,y0} = {a,b,c,d} XOR {key3,key2,key1,key0}.
- Outputs come from four flip-flops only (no combinational path from inputs to outputs).
- Latency: the result of the inputs sampled at rising edge N is visible on y after edge N and held until edge N+1.
- No enable. Inputs are sampled on every rising edge.
- Reset:
  - rst_n low asynchronously forces y3..y0 = 0000 immediately, independent of clk.
  - Outputs hold 0000 for as long as rst_n stays low.
  - On the first rising edge after rst_n deasserts, y takes data^key of the inputs present at that edge.
- Reset asserted mid-stream discards the in-flight result. No residual state survives reset.
- Involution property: applying the block twice with the same key returns the original data.
- Key 0000 is the identity (y = data). Key 1111 bitwise inverts data. Data equal to key yields 0000.
- Inputs at X/Z are not required to be handled. The bench drives only 0/1 once out of reset.
- No internal state other than the four output registers.

Test Plan:
- Reset: hold rst_n=0 with data=1010, key=0101, and toggle clk -> y=0000 throughout. Assert rst_n=0 between clock edges while y=1111 -> y goes to 0000 immediately, without a clock edge.
- Exhaustive sweep:
  - After reset, drive i=0..255 as {a,b,c,d,key3,key2,key1,key0}=i, one value per clock.
  - After each edge, y must equal i[7:4]^i[3:0].
  - Spot checks: i=0 -> 0000; i=255 -> 0000; i=0xA5 -> 1111; i=0x3C -> 1111; i=0x90 -> 1001.
- Latency:
  - Change inputs from data=0001/key=0000 to data=1110/key=0000 just after a rising edge.
  - y stays 0001 until the next rising edge, then becomes 1110.
- Round trip: encrypt data=1011 with key=0110 -> y=1101. Feed 1101 back as data with key=0110 -> y=1011.
- Reset mid-operation:
  - Stream alternating data 1111/0000 with key=0000.
  - Pulse rst_n low for half a cycle -> y=0000 during the pulse.
  - At the first rising edge after release, y equals the current data.
